// File: rtl/xalu_pkg.sv
// Shared encodings and defaults for the E-stage multiply/divide sequencer.
// Consumed by xalu_arith and xalu_scheduler.
package xalu_pkg;

  localparam logic [2:0] XOP_NONE  = 3'b000;
  localparam logic [2:0] XOP_MULT  = 3'b001;
  localparam logic [2:0] XOP_MULTU = 3'b010;
  localparam logic [2:0] XOP_DIV   = 3'b011;
  localparam logic [2:0] XOP_DIVU  = 3'b100;
  localparam logic [2:0] XOP_MTHI  = 3'b101;
  localparam logic [2:0] XOP_MTLO  = 3'b110;
  localparam logic [2:0] XOP_NONE7 = 3'b111;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam int MULT_LAT_DEF = 5;
  localparam int DIV_LAT_DEF  = 10;
  localparam int CNT_W_DEF    = 4;

  // True for the four ops that occupy the busy window.
  function automatic logic is_md_op(input logic [2:0] op);
    return (op == XOP_MULT) || (op == XOP_MULTU) || (op == XOP_DIV) || (op == XOP_DIVU);
  endfunction

  function automatic logic is_div_op(input logic [2:0] op);
    return (op == XOP_DIV) || (op == XOP_DIVU);
  endfunction

endpackage

// File: rtl/xalu_arith.sv
// Combinational multiply/divide datapath: {res_hi,res_lo} for mult/multu/div/divu,
// including the divide-by-zero and INT_MIN/-1 results.
module xalu_arith
  import xalu_pkg::*;
(
  input  logic [2:0]  op_i,
  input  logic [31:0] rs_i,
  input  logic [31:0] rt_i,
  output logic [31:0] res_hi_o,
  output logic [31:0] res_lo_o
);

  logic [63:0]        prod_s;
  logic [63:0]        prod_u;
  logic               div_zero;
  logic               div_ovf;
  logic [31:0]        div_s;
  logic [31:0]        div_u;
  logic signed [31:0] quot_s;
  logic signed [31:0] rem_s;
  logic [31:0]        quot_u;
  logic [31:0]        rem_u;

  assign prod_s = {{32{rs_i[31]}}, rs_i} * {{32{rt_i[31]}}, rt_i};
  assign prod_u = {32'd0, rs_i} * {32'd0, rt_i};

  // Substituting a divisor of 1 keeps the divider defined; for INT_MIN/-1 it
  // also yields exactly the required quotient INT_MIN and remainder 0.
  assign div_zero = (rt_i == 32'd0);
  assign div_ovf  = (rs_i == 32'h8000_0000) && (rt_i == 32'hFFFF_FFFF);
  assign div_s    = (div_zero || div_ovf) ? 32'd1 : rt_i;
  assign div_u    = div_zero ? 32'd1 : rt_i;

  assign quot_s = $signed(rs_i) / $signed(div_s);
  assign rem_s  = $signed(rs_i) % $signed(div_s);
  assign quot_u = rs_i / div_u;
  assign rem_u  = rs_i % div_u;

  always_comb begin
    res_hi_o = 32'd0;
    res_lo_o = 32'd0;
    case (op_i)
      XOP_MULT:  {res_hi_o, res_lo_o} = prod_s;
      XOP_MULTU: {res_hi_o, res_lo_o} = prod_u;
      XOP_DIV: begin
        res_hi_o = div_zero ? rs_i : rem_s;
        res_lo_o = div_zero ? 32'hFFFF_FFFF : quot_s;
      end
      XOP_DIVU: begin
        res_hi_o = div_zero ? rs_i : rem_u;
        res_lo_o = div_zero ? 32'hFFFF_FFFF : quot_u;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/xalu_scheduler.sv
// E-stage multiply/divide sequencer: IDLE/RUN FSM, fixed-latency busy window, HI/LO commit.
// Optional XALU_CANCEL_EN adds a cancel input that aborts the in-flight op.
module xalu_scheduler
  import xalu_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  xalu_op_e,
  input  logic [31:0] rs_e,
  input  logic [31:0] rt_e,
`ifdef XALU_CANCEL_EN
  input  logic        cancel,
`endif
  output logic        start,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [0:0]  dbg_state_o
);

  localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_LAT - 1);

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      pend_hi_q, pend_hi_d;
  logic [31:0]      pend_lo_q, pend_lo_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic [31:0]      res_hi, res_lo;
  logic             cancel_w;

`ifdef XALU_CANCEL_EN
  assign cancel_w = cancel;
`else
  assign cancel_w = 1'b0;
`endif

  xalu_arith u_arith (
    .op_i     (xalu_op_e),
    .rs_i     (rs_e),
    .rt_i     (rt_e),
    .res_hi_o (res_hi),
    .res_lo_o (res_lo)
  );

  // Handshake: start pulses for one cycle when an md op is taken in IDLE; while busy
  // (or start) is high the hazard unit holds md ops in D, so anything arriving in RUN is dropped.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    start     = 1'b0;
    if (cancel_w) begin
      state_d   = S_IDLE;
      cnt_d     = '0;
      pend_hi_d = 32'd0;
      pend_lo_d = 32'd0;
    end else if (state_q == S_IDLE) begin
      if (is_md_op(xalu_op_e)) begin
        start     = 1'b1;
        state_d   = S_RUN;
        cnt_d     = is_div_op(xalu_op_e) ? DIV_CNT : MULT_CNT;
        pend_hi_d = res_hi;
        pend_lo_d = res_lo;
      end else if (xalu_op_e == XOP_MTHI) begin
        hi_d = rs_e;
      end else if (xalu_op_e == XOP_MTLO) begin
        lo_d = rs_e;
      end
    end else begin
      if (cnt_q == '0) begin
        hi_d    = pend_hi_q;
        lo_d    = pend_lo_q;
        state_d = S_IDLE;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign busy        = (state_q == S_RUN);
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign dbg_state_o = state_q;

`ifndef SYNTHESIS
  // Flags a hazard-contract breach: the op is silently dropped by the FSM.
  always @(posedge clk) begin
    if (reset && (state_q == S_RUN)) begin
      assert ((xalu_op_e == XOP_NONE) || (xalu_op_e == XOP_NONE7))
        else $warning("xalu_scheduler: op %0d arrived while busy and was dropped", xalu_op_e);
    end
  end
`endif

endmodule
